eth_rx_fcs_monitor: RTL and testbench

//  Passive per-port frame checker on an MII/GMII receive or transmit data path.

---
 rtl/eth_rx_fcs_monitor.sv | 174 +++++++++++++++++
 tb/tb_eth_rx_fcs_monitor.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_fcs_monitor.sv
// Passive MII/GMII frame checker: preamble/SFD hunt, CRC-32 residue check,
// length/alignment flags, captured FCS and saturating good/bad counters.
module eth_rx_fcs_monitor #(
  parameter int DATA_W    = 4,
  parameter int CNT_W     = 16,
  parameter int LEN_W     = 12,
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dv,
  input  logic [DATA_W-1:0] d,
  input  logic              cnt_clr,
  output logic              frame_done,
  output logic              frame_ok,
  output logic              err_crc,
  output logic              err_len,
  output logic              err_align,
  output logic [LEN_W-1:0]  frame_len,
  output logic [31:0]       fcs_value,
  output logic [CNT_W-1:0]  good_cnt,
  output logic [CNT_W-1:0]  bad_cnt
);

  localparam logic [31:0] POLY    = 32'hEDB88320;
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_FRAME);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_FRAME);

  typedef enum logic [2:0] {
    IDLE, PRE, DATA, CHK, DROP
  } state_t;

  state_t state;

  logic [31:0]      crc;
  logic [31:0]      fcs_sh;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] len_inc;
  logic [7:0]       lane_byte;
  logic             byte_vld;
  logic             odd_nib;
  logic             pre_hit;
  logic             sfd_hit;
  logic             in_data;
  logic             crc_bad;
  logic             len_bad;

  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  b
  );
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    return r;
  endfunction

  assign in_data = (state == DATA) && dv;

  generate
    if (DATA_W == 8) begin : g_byte
      assign lane_byte = d;
      assign byte_vld  = in_data;
      assign odd_nib   = 1'b0;
      assign pre_hit   = (d == 8'h55);
      assign sfd_hit   = (d == 8'hD5);
    end else begin : g_nib
      logic       half;
      logic [3:0] lo_nib;

      // low nibble arrives first; a byte completes on every odd nibble
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          half   <= 1'b0;
          lo_nib <= 4'h0;
        end else if (in_data) begin
          half <= ~half;
          if (!half)
            lo_nib <= d;
        end else begin
          half <= 1'b0;
        end
      end

      assign lane_byte = {d, lo_nib};
      assign byte_vld  = in_data && half;
      assign odd_nib   = half;
      assign pre_hit   = (d == 4'h5);
      assign sfd_hit   = (d == 4'hD);
    end
  endgenerate

  assign len_inc = (&len) ? len : len + 1'b1;
  assign crc_bad = (crc != RESIDUE);
  assign len_bad = (len < MIN_L) || (len > MAX_L);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      crc        <= 32'hFFFFFFFF;
      fcs_sh     <= 32'h0;
      len        <= '0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      err_crc    <= 1'b0;
      err_len    <= 1'b0;
      err_align  <= 1'b0;
      frame_len  <= '0;
      fcs_value  <= 32'h0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;

      // status is registered on entry to CHK, so count during CHK
      if (cnt_clr) begin
        good_cnt <= '0;
        bad_cnt  <= '0;
      end else if (state == CHK) begin
        if (frame_ok)
          good_cnt <= (&good_cnt) ? good_cnt : good_cnt + 1'b1;
        else
          bad_cnt  <= (&bad_cnt) ? bad_cnt : bad_cnt + 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (dv)
            state <= pre_hit ? PRE : DROP;
        end
        PRE: begin
          if (!dv) begin
            state <= DROP;
          end else if (sfd_hit) begin
            state  <= DATA;
            crc    <= 32'hFFFFFFFF;
            len    <= '0;
            fcs_sh <= 32'h0;
          end else if (!pre_hit) begin
            state <= DROP;
          end
        end
        DATA: begin
          if (!dv) begin
            state      <= CHK;
            frame_done <= 1'b1;
            err_crc    <= crc_bad;
            err_len    <= len_bad;
            err_align  <= odd_nib;
            frame_ok   <= ~(crc_bad | len_bad | odd_nib);
            frame_len  <= len;
            fcs_value  <= fcs_sh;
          end else if (byte_vld) begin
            crc    <= crc_byte(crc, lane_byte);
            len    <= len_inc;
            fcs_sh <= {lane_byte, fcs_sh[31:8]};
          end
        end
        CHK: begin
          state <= IDLE;
        end
        DROP: begin
          if (!dv)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_rx_fcs_monitor.sv
// Directed bench for eth_rx_fcs_monitor: GMII and MII instances, CRC-32
// check value frame "123456789", drop, reset and counter saturation cases.
module tb_eth_rx_fcs_monitor;

  localparam logic [7:0] FRM [13] = '{
    8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
    8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB
  };

  logic       clk = 1'b0;
  logic       reset;
  logic       cnt_clr;
  logic       dv8;
  logic [7:0] d8;
  logic       dv4;
  logic [3:0] d4;

  int n_err = 0;
  int n_chk = 0;

  logic        a_done, a_ok, a_crc, a_len, a_align;
  logic [11:0] a_flen;
  logic [31:0] a_fcs;
  logic [1:0]  a_good, a_bad;

  logic        b_done, b_ok, b_crc, b_len, b_align;
  logic [11:0] b_flen;
  logic [31:0] b_fcs;
  logic [15:0] b_good, b_bad;

  logic        n_done, n_ok, n_crc, n_len, n_align;
  logic [11:0] n_flen;
  logic [31:0] n_fcs;
  logic [15:0] n_good, n_bad;

  always #5 clk = ~clk;

  eth_rx_fcs_monitor #(
    .DATA_W(8), .CNT_W(2), .LEN_W(12),
    .MIN_FRAME(1), .MAX_FRAME(1518)
  ) u8a (
    .clk(clk), .reset(reset), .dv(dv8), .d(d8),
    .cnt_clr(cnt_clr), .frame_done(a_done),
    .frame_ok(a_ok), .err_crc(a_crc),
    .err_len(a_len), .err_align(a_align),
    .frame_len(a_flen), .fcs_value(a_fcs),
    .good_cnt(a_good), .bad_cnt(a_bad)
  );

  eth_rx_fcs_monitor #(
    .DATA_W(8), .CNT_W(16), .LEN_W(12),
    .MIN_FRAME(64), .MAX_FRAME(1518)
  ) u8b (
    .clk(clk), .reset(reset), .dv(dv8), .d(d8),
    .cnt_clr(cnt_clr), .frame_done(b_done),
    .frame_ok(b_ok), .err_crc(b_crc),
    .err_len(b_len), .err_align(b_align),
    .frame_len(b_flen), .fcs_value(b_fcs),
    .good_cnt(b_good), .bad_cnt(b_bad)
  );

  eth_rx_fcs_monitor #(
    .DATA_W(4), .CNT_W(16), .LEN_W(12),
    .MIN_FRAME(1), .MAX_FRAME(1518)
  ) u4 (
    .clk(clk), .reset(reset), .dv(dv4), .d(d4),
    .cnt_clr(cnt_clr), .frame_done(n_done),
    .frame_ok(n_ok), .err_crc(n_crc),
    .err_len(n_len), .err_align(n_align),
    .frame_len(n_flen), .fcs_value(n_fcs),
    .good_cnt(n_good), .bad_cnt(n_bad)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic put8(input logic [7:0] b);
    @(negedge clk);
    dv8 = 1'b1;
    d8  = b;
  endtask

  task automatic put4(input logic [3:0] n);
    @(negedge clk);
    dv4 = 1'b1;
    d4  = n;
  endtask

  task automatic pre8();
    for (int i = 0; i < 7; i++) put8(8'h55);
    put8(8'hD5);
  endtask

  task automatic body8(input bit flip);
    logic [7:0] b;
    for (int i = 0; i < 13; i++) begin
      b = FRM[i];
      if (flip && i == 4) b[0] = ~b[0];
      put8(b);
    end
  endtask

  task automatic end8();
    @(negedge clk);
    dv8 = 1'b0;
    d8  = 8'h00;
  endtask

  task automatic frame4(input bit extra);
    logic [7:0] b;
    for (int i = 0; i < 15; i++) put4(4'h5);
    put4(4'hD);
    for (int i = 0; i < 13; i++) begin
      b = FRM[i];
      put4(b[3:0]);
      put4(b[7:4]);
    end
    if (extra) put4(4'h0);
    @(negedge clk);
    dv4 = 1'b0;
    d4  = 4'h0;
  endtask

  initial begin
    bit seen;
    reset   = 1'b1;
    cnt_clr = 1'b0;
    dv8 = 1'b0; d8 = 8'h00;
    dv4 = 1'b0; d4 = 4'h0;
    repeat (2) @(negedge clk);
    check("rst_done",  {31'h0, a_done}, 32'd0);
    check("rst_ok",    {31'h0, a_ok},   32'd0);
    check("rst_len",   {20'h0, a_flen}, 32'd0);
    check("rst_fcs",   a_fcs,           32'd0);
    check("rst_good4", {16'h0, n_good}, 32'd0);
    reset = 1'b0;

    // T1 / T2: good GMII frame; u8b rejects it on length
    pre8(); body8(1'b0); end8();
    check("t1_lat", {31'h0, a_done}, 32'd0);
    @(negedge clk);
    check("t1_done", {31'h0, a_done}, 32'd1);
    check("t1_ok",   {31'h0, a_ok},   32'd1);
    check("t1_crc",  {31'h0, a_crc},  32'd0);
    check("t1_flen", {20'h0, a_flen}, 32'd13);
    check("t1_fcs",  a_fcs, 32'hCBF43926);
    check("t2_done", {31'h0, b_done}, 32'd1);
    check("t2_elen", {31'h0, b_len},  32'd1);
    check("t2_ecrc", {31'h0, b_crc},  32'd0);
    check("t2_ok",   {31'h0, b_ok},   32'd0);
    @(negedge clk);
    check("t1_pulse", {31'h0, a_done}, 32'd0);
    check("t1_good",  {30'h0, a_good}, 32'd1);
    check("t1_bad",   {30'h0, a_bad},  32'd0);
    check("t1_hold",  {20'h0, a_flen}, 32'd13);
    check("t2_bad",   {16'h0, b_bad},  32'd1);
    check("t2_good",  {16'h0, b_good}, 32'd0);

    // T3: same frame over MII
    frame4(1'b0);
    check("t3_lat", {31'h0, n_done}, 32'd0);
    @(negedge clk);
    check("t3_done",  {31'h0, n_done},  32'd1);
    check("t3_ok",    {31'h0, n_ok},    32'd1);
    check("t3_align", {31'h0, n_align}, 32'd0);
    check("t3_flen",  {20'h0, n_flen},  32'd13);
    check("t3_fcs",   n_fcs, 32'hCBF43926);
    @(negedge clk);
    check("t3_good", {16'h0, n_good}, 32'd1);

    // T4: trailing odd nibble
    frame4(1'b1);
    @(negedge clk);
    check("t4_done",  {31'h0, n_done},  32'd1);
    check("t4_align", {31'h0, n_align}, 32'd1);
    check("t4_crc",   {31'h0, n_crc},   32'd0);
    check("t4_flen",  {20'h0, n_flen},  32'd13);
    check("t4_ok",    {31'h0, n_ok},    32'd0);
    @(negedge clk);
    check("t4_bad", {16'h0, n_bad}, 32'd1);

    // T5: corrupted payload bit
    pre8(); body8(1'b1); end8();
    @(negedge clk);
    check("t5_done", {31'h0, a_done}, 32'd1);
    check("t5_crc",  {31'h0, a_crc},  32'd1);
    check("t5_ok",   {31'h0, a_ok},   32'd0);
    check("t5_fcs",  a_fcs, 32'hCBF43926);
    @(negedge clk);
    check("t5_bad",  {30'h0, a_bad},  32'd1);
    check("t5_good", {30'h0, a_good}, 32'd1);

    // bad SFD: dropped without a report
    for (int i = 0; i < 3; i++) put8(8'h55);
    put8(8'h12); put8(8'h31); put8(8'h32);
    end8();
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen = seen | a_done | b_done;
    end
    check("drop_done", {31'h0, seen},   32'd0);
    check("drop_good", {30'h0, a_good}, 32'd1);
    check("drop_bad",  {30'h0, a_bad},  32'd1);

    // T6: reset in the middle of DATA
    pre8();
    for (int i = 0; i < 5; i++) put8(FRM[i]);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t6_good", {30'h0, a_good}, 32'd0);
    check("t6_bad",  {30'h0, a_bad},  32'd0);
    check("t6_flen", {20'h0, a_flen}, 32'd0);
    check("t6_fcs",  a_fcs, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 5; i < 13; i++) put8(FRM[i]);
    end8();
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen = seen | a_done;
    end
    check("t6_nodone", {31'h0, seen}, 32'd0);

    // saturate the 2-bit good counter
    for (int k = 0; k < 3; k++) begin
      pre8(); body8(1'b0); end8();
      repeat (3) @(negedge clk);
    end
    check("sat_3", {30'h0, a_good}, 32'd3);
    pre8(); body8(1'b0); end8();
    repeat (3) @(negedge clk);
    check("sat_hold", {30'h0, a_good}, 32'd3);

    // clear coincident with frame_done at saturation
    pre8(); body8(1'b0); end8();
    @(negedge clk);
    check("clr_done", {31'h0, a_done}, 32'd1);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    check("clr_good", {30'h0, a_good}, 32'd0);
    check("clr_bad",  {30'h0, a_bad},  32'd0);
    @(negedge clk);
    check("clr_stay", {30'h0, a_good}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
